// File: rtl/sol32_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sol32_bus_pkg
// Purpose  : Shared types and constants for the sol32 memory sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package sol32_bus_pkg;

  // Sequencer states, one instruction per FETCH..COMMIT pass
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    DISPATCH = 3'd2,
    DATA     = 3'd3,
    COMMIT   = 3'd4,
    FAULT    = 3'd5
  } seq_state_t;

  // Bus access width encodings
  localparam logic [1:0] WidthByte = 2'b00;
  localparam logic [1:0] WidthHalf = 2'b01;
  localparam logic [1:0] WidthWord = 2'b10;

endpackage
`default_nettype wire

// File: rtl/sol32_bus_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : sol32_bus_watchdog
// Purpose  : Counts consecutive unacknowledged bus-request cycles and flags
//            expiry on the cycle the count reaches TimeoutCycles. An ack in
//            that same cycle wins, so Expired is never raised alongside Ack.
// Revision : 1.0 - initial release
// ============================================================================
module sol32_bus_watchdog #(
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Active,
  input  logic Ack,
  output logic Expired
);

  generate
    if (TimeoutCycles == 0) begin : g_disabled
      assign Expired = 1'b0;
    end else begin : g_enabled
      // Counter only needs to reach TimeoutCycles-1; the next stalled cycle expires
      localparam int c_cnt_w = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
      localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TimeoutCycles - 1);

      logic [c_cnt_w-1:0] r_count;

      // Advance on each stalled request cycle; any ack or idle bus clears it
      always_ff @(posedge Clock) begin
        if (!Reset) begin
          r_count <= '0;
        end else if (Active && !Ack) begin
          r_count <= r_count + c_cnt_w'(1);
        end else begin
          r_count <= '0;
        end
      end

      assign Expired = Active && !Ack && (r_count == c_limit);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/sol32_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sol32_mem_sequencer
// Purpose  : Serialises sol32core instruction fetch and one optional
//            load/store per instruction onto a single shared memory bus,
//            with a sticky bus-timeout fault.
// Revision : 1.0 - initial release
// ============================================================================
module sol32_mem_sequencer
  import sol32_bus_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 255,
  parameter logic [1:0]  FetchWidth    = WidthWord
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] InstructionPointer,
  output logic [31:0] Instruction,
  output logic        InstructionReady,
  input  logic        ReadEnable,
  input  logic        WriteEnable,
  input  logic [1:0]  DataWidth,
  input  logic [31:0] DataOut,
  input  logic [31:0] MemoryAddress,
  output logic [31:0] DataIn,
  output logic        ReadComplete,
  output logic        WriteComplete,
  output logic        BusRequest,
  output logic        BusWrite,
  output logic [1:0]  BusWidth,
  output logic [31:0] BusAddress,
  output logic [31:0] BusWriteData,
  input  logic [31:0] BusReadData,
  input  logic        BusAck,
  output logic        Fault
);

  seq_state_t  r_state;
  seq_state_t  w_state_next;
  logic        w_ack;
  logic        w_expired;
  logic        w_load_fetch;
  logic        w_load_data;
  logic        w_ready;
  logic        r_bus_req;
  logic        r_bus_write;
  logic [1:0]  r_bus_width;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [31:0] r_instruction;
  logic [31:0] r_data_in;

  // An ack only counts while a request is actually outstanding
  assign w_ack = BusAck & r_bus_req;

  sol32_bus_watchdog #(
    .TimeoutCycles (TimeoutCycles)
  ) u_watchdog (
    .Clock   (Clock),
    .Reset   (Reset),
    .Active  (r_bus_req),
    .Ack     (BusAck),
    .Expired (w_expired)
  );

  // State register
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic plus bus-load strobes and the core release pulse
  always_comb begin
    w_state_next = r_state;
    w_load_fetch = 1'b0;
    w_load_data  = 1'b0;
    w_ready      = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_next = FETCH;
        w_load_fetch = 1'b1;
      end
      FETCH: begin
        if (w_expired) begin
          w_state_next = FAULT;
        end else if (w_ack) begin
          w_state_next = DISPATCH;
        end
      end
      DISPATCH: begin
        if (ReadEnable || WriteEnable) begin
          w_state_next = DATA;
          w_load_data  = 1'b1;
        end else begin
          w_ready      = 1'b1;
          w_state_next = FETCH;
          w_load_fetch = 1'b1;
        end
      end
      DATA: begin
        if (w_expired) begin
          w_state_next = FAULT;
        end else if (w_ack) begin
          w_state_next = COMMIT;
        end
      end
      COMMIT: begin
        w_ready      = 1'b1;
        w_state_next = FETCH;
        w_load_fetch = 1'b1;
      end
      FAULT: begin
        w_state_next = FAULT;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Bus outputs are captured on entry to FETCH/DATA and held until ack or timeout
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_bus_req   <= 1'b0;
      r_bus_write <= 1'b0;
      r_bus_width <= 2'b00;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
    end else if (w_load_fetch) begin
      r_bus_req   <= 1'b1;
      r_bus_write <= 1'b0;
      r_bus_width <= FetchWidth;
      r_bus_addr  <= InstructionPointer;
    end else if (w_load_data) begin
      // A simultaneous read and write request resolves to a write
      r_bus_req   <= 1'b1;
      r_bus_write <= WriteEnable;
      r_bus_width <= DataWidth;
      r_bus_addr  <= MemoryAddress;
      r_bus_wdata <= DataOut;
    end else if (w_ack || w_expired) begin
      r_bus_req   <= 1'b0;
    end
  end

  // Capture the fetched instruction word
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_instruction <= '0;
    end else if (r_state == FETCH && w_ack) begin
      r_instruction <= BusReadData;
    end
  end

  // Capture load data; stores and non-memory instructions leave it untouched
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_data_in <= '0;
    end else if (r_state == DATA && w_ack && !r_bus_write) begin
      r_data_in <= BusReadData;
    end
  end

  assign Instruction      = r_instruction;
  assign DataIn           = r_data_in;
  assign InstructionReady = w_ready;
  assign ReadComplete     = !(r_state == DATA && !r_bus_write);
  assign WriteComplete    = !(r_state == DATA &&  r_bus_write);
  assign BusRequest       = r_bus_req;
  assign BusWrite         = r_bus_write;
  assign BusWidth         = r_bus_width;
  assign BusAddress       = r_bus_addr;
  assign BusWriteData     = r_bus_wdata;
  assign Fault            = (r_state == FAULT);

endmodule
`default_nettype wire

// File: tb/tb_sol32_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sol32_mem_sequencer
// Purpose  : Directed self-checking bench for sol32_mem_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sol32_mem_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] InstructionPointer;
  logic [31:0] Instruction;
  logic        InstructionReady;
  logic        ReadEnable;
  logic        WriteEnable;
  logic [1:0]  DataWidth;
  logic [31:0] DataOut;
  logic [31:0] MemoryAddress;
  logic [31:0] DataIn;
  logic        ReadComplete;
  logic        WriteComplete;
  logic        BusRequest;
  logic        BusWrite;
  logic [1:0]  BusWidth;
  logic [31:0] BusAddress;
  logic [31:0] BusWriteData;
  logic [31:0] BusReadData;
  logic        BusAck;
  logic        Fault;

  int errors = 0;
  int checks = 0;

  always #5 Clock = ~Clock;

  sol32_mem_sequencer #(
    .TimeoutCycles (4),
    .FetchWidth    (2'b10)
  ) dut (
    .Clock              (Clock),
    .Reset              (Reset),
    .InstructionPointer (InstructionPointer),
    .Instruction        (Instruction),
    .InstructionReady   (InstructionReady),
    .ReadEnable         (ReadEnable),
    .WriteEnable        (WriteEnable),
    .DataWidth          (DataWidth),
    .DataOut            (DataOut),
    .MemoryAddress      (MemoryAddress),
    .DataIn             (DataIn),
    .ReadComplete       (ReadComplete),
    .WriteComplete      (WriteComplete),
    .BusRequest         (BusRequest),
    .BusWrite           (BusWrite),
    .BusWidth           (BusWidth),
    .BusAddress         (BusAddress),
    .BusWriteData       (BusWriteData),
    .BusReadData        (BusReadData),
    .BusAck             (BusAck),
    .Fault              (Fault)
  );

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0; InstructionPointer = '0; ReadEnable = 1'b0; WriteEnable = 1'b0;
    DataWidth = 2'b00; DataOut = '0; MemoryAddress = '0; BusReadData = '0; BusAck = 1'b0;
    repeat (2) step();
    checks++; if (BusRequest !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", BusRequest); end
    checks++; if (ReadComplete !== 1'b1 || WriteComplete !== 1'b1) begin errors++; $display("FAIL reset_complete: got rc=%b wc=%b want 1/1", ReadComplete, WriteComplete); end
    checks++; if (InstructionReady !== 1'b0 || Fault !== 1'b0) begin errors++; $display("FAIL reset_ready_fault: got rdy=%b fault=%b want 0/0", InstructionReady, Fault); end
    checks++; if (Instruction !== 32'h0 || DataIn !== 32'h0) begin errors++; $display("FAIL reset_latches: got ins=%h din=%h want 0/0", Instruction, DataIn); end
  endtask

  task automatic test_fetch();
    Reset = 1'b1;
    step(); // FETCH
    checks++; if (BusRequest !== 1'b1 || BusAddress !== 32'h0 || BusWidth !== 2'b10 || BusWrite !== 1'b0) begin errors++;
      $display("FAIL fetch_bus: got req=%b addr=%h w=%b wr=%b want 1/0/10/0", BusRequest, BusAddress, BusWidth, BusWrite); end
    checks++; if (InstructionReady !== 1'b0) begin errors++; $display("FAIL fetch_ready: got %b want 0", InstructionReady); end
    BusAck = 1'b1; BusReadData = 32'h0000_0012;
    step(); // DISPATCH
    BusAck = 1'b0; BusReadData = '0; InstructionPointer = 32'h4; #1;
    checks++; if (Instruction !== 32'h12) begin errors++; $display("FAIL fetch_instr: got %h want 00000012", Instruction); end
    checks++; if (InstructionReady !== 1'b1 || BusRequest !== 1'b0) begin errors++; $display("FAIL dispatch_ready: got rdy=%b req=%b want 1/0", InstructionReady, BusRequest); end
    step(); // FETCH
    checks++; if (InstructionReady !== 1'b0 || BusRequest !== 1'b1 || BusAddress !== 32'h4) begin errors++;
      $display("FAIL refetch: got rdy=%b req=%b addr=%h want 0/1/4", InstructionReady, BusRequest, BusAddress); end
  endtask

  task automatic test_load();
    int rc_low = 0;
    int rdy = 0;
    BusAck = 1'b1; BusReadData = 32'h0000_0003;
    step(); // DISPATCH
    BusAck = 1'b0; ReadEnable = 1'b1; MemoryAddress = 32'h100; DataWidth = 2'b00; #1;
    checks++; if (InstructionReady !== 1'b0) begin errors++; $display("FAIL load_dispatch_ready: got %b want 0", InstructionReady); end
    step(); // DATA, first cycle
    checks++; if (BusRequest !== 1'b1 || BusWrite !== 1'b0 || BusWidth !== 2'b00 || BusAddress !== 32'h100) begin errors++;
      $display("FAIL load_bus: got req=%b wr=%b w=%b addr=%h want 1/0/00/100", BusRequest, BusWrite, BusWidth, BusAddress); end
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin BusAck = 1'b1; BusReadData = 32'h0000_00A5; end
      #1;
      if (!ReadComplete) rc_low++;
      if (InstructionReady) rdy++;
      step();
    end
    BusAck = 1'b0; BusReadData = 32'hFFFF_FFFF; #1; // COMMIT
    if (InstructionReady) rdy++;
    checks++; if (DataIn !== 32'h0000_00A5) begin errors++; $display("FAIL load_data: got %h want 000000a5", DataIn); end
    checks++; if (ReadComplete !== 1'b1 || BusRequest !== 1'b0 || Fault !== 1'b0) begin errors++;
      $display("FAIL load_commit: got rc=%b req=%b fault=%b want 1/0/0", ReadComplete, BusRequest, Fault); end
    ReadEnable = 1'b0;
    step(); // FETCH
    if (InstructionReady) rdy++;
    checks++; if (rc_low != 4) begin errors++; $display("FAIL load_rc_low_cycles: got %0d want 4", rc_low); end
    checks++; if (rdy != 1) begin errors++; $display("FAIL load_ready_pulses: got %0d want 1", rdy); end
  endtask

  task automatic test_store();
    BusAck = 1'b1; BusReadData = 32'h0000_0023;
    step(); // DISPATCH
    BusAck = 1'b0; WriteEnable = 1'b1; MemoryAddress = 32'h200; DataOut = 32'hDEAD_BEEF; DataWidth = 2'b10;
    step(); // DATA
    checks++; if (BusWrite !== 1'b1 || BusWriteData !== 32'hDEAD_BEEF || BusAddress !== 32'h200) begin errors++;
      $display("FAIL store_bus: got wr=%b wd=%h addr=%h want 1/deadbeef/200", BusWrite, BusWriteData, BusAddress); end
    checks++; if (WriteComplete !== 1'b0 || ReadComplete !== 1'b1) begin errors++; $display("FAIL store_complete: got wc=%b rc=%b want 0/1", WriteComplete, ReadComplete); end
    step(); // DATA wait
    checks++; if (WriteComplete !== 1'b0 || BusRequest !== 1'b1) begin errors++; $display("FAIL store_wait: got wc=%b req=%b want 0/1", WriteComplete, BusRequest); end
    BusAck = 1'b1; BusReadData = 32'h1234_5678;
    step(); // COMMIT
    BusAck = 1'b0; WriteEnable = 1'b0; #1;
    checks++; if (WriteComplete !== 1'b1 || InstructionReady !== 1'b1) begin errors++; $display("FAIL store_commit: got wc=%b rdy=%b want 1/1", WriteComplete, InstructionReady); end
    checks++; if (DataIn !== 32'h0000_00A5) begin errors++; $display("FAIL store_datain_hold: got %h want 000000a5", DataIn); end
    step(); // FETCH
  endtask

  task automatic test_both_enables();
    BusAck = 1'b1; BusReadData = 32'h0000_0033;
    step(); // DISPATCH
    BusAck = 1'b0; ReadEnable = 1'b1; WriteEnable = 1'b1; MemoryAddress = 32'h300; DataOut = 32'h1122_3344;
    step(); // DATA
    checks++; if (BusWrite !== 1'b1 || WriteComplete !== 1'b0 || ReadComplete !== 1'b1) begin errors++;
      $display("FAIL both_is_write: got wr=%b wc=%b rc=%b want 1/0/1", BusWrite, WriteComplete, ReadComplete); end
    BusAck = 1'b1; BusReadData = 32'hFFFF_FFFF;
    step(); // COMMIT
    BusAck = 1'b0; ReadEnable = 1'b0; WriteEnable = 1'b0;
    checks++; if (DataIn !== 32'h0000_00A5) begin errors++; $display("FAIL both_datain_hold: got %h want 000000a5", DataIn); end
    step(); // FETCH
  endtask

  task automatic test_ack_at_limit();
    repeat (3) step(); // three stalled fetch cycles
    BusAck = 1'b1; BusReadData = 32'h0000_0055;
    step(); // DISPATCH
    BusAck = 1'b0; #1;
    checks++; if (Fault !== 1'b0 || Instruction !== 32'h55 || InstructionReady !== 1'b1) begin errors++;
      $display("FAIL ack_at_limit: got fault=%b ins=%h rdy=%b want 0/55/1", Fault, Instruction, InstructionReady); end
    // Ack while no request is outstanding must be ignored
    BusAck = 1'b1; BusReadData = 32'h0000_0BAD;
    step(); // FETCH
    BusAck = 1'b0; BusReadData = '0;
    checks++; if (Instruction !== 32'h55 || BusRequest !== 1'b1 || Fault !== 1'b0) begin errors++;
      $display("FAIL spurious_ack: got ins=%h req=%b fault=%b want 55/1/0", Instruction, BusRequest, Fault); end
  endtask

  task automatic test_mid_reset();
    BusAck = 1'b1; BusReadData = 32'h0000_0003;
    step(); // DISPATCH
    BusAck = 1'b0; ReadEnable = 1'b1; MemoryAddress = 32'h180;
    step(); // DATA
    step(); // DATA wait
    Reset = 1'b0;
    step();
    checks++; if (BusRequest !== 1'b0 || ReadComplete !== 1'b1 || Instruction !== 32'h0 || DataIn !== 32'h0) begin errors++;
      $display("FAIL mid_reset: got req=%b rc=%b ins=%h din=%h want 0/1/0/0", BusRequest, ReadComplete, Instruction, DataIn); end
    Reset = 1'b1; ReadEnable = 1'b0; InstructionPointer = 32'h40;
    step(); // FETCH
    checks++; if (BusRequest !== 1'b1 || BusAddress !== 32'h40) begin errors++;
      $display("FAIL restart_fetch: got req=%b addr=%h want 1/40", BusRequest, BusAddress); end
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    int rdy = 0;
    int fault_low = 0;
    for (int i = 0; i < 8; i++) begin
      if (BusRequest) req_cycles++;
      step();
    end
    checks++; if (req_cycles != 4) begin errors++; $display("FAIL timeout_req_cycles: got %0d want 4", req_cycles); end
    checks++; if (Fault !== 1'b1) begin errors++; $display("FAIL timeout_fault: got %b want 1", Fault); end
    BusAck = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (InstructionReady) rdy++;
      if (!Fault || BusRequest) fault_low++;
      step();
    end
    BusAck = 1'b0;
    checks++; if (rdy != 0 || fault_low != 0) begin errors++; $display("FAIL fault_sticky: got rdy=%0d bad=%0d want 0/0", rdy, fault_low); end
    Reset = 1'b0;
    step();
    checks++; if (Fault !== 1'b0) begin errors++; $display("FAIL fault_reset_clear: got %b want 0", Fault); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_both_enables();
    test_ack_at_limit();
    test_mid_reset();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
